ddr_port_arbiter: RTL and testbench
===================================

# ddr_port_arbiter

Round-robin burst arbiter that shares one AXI DDR master interface (the `axi_start`/`axi_ready`/`axi_done` burst-request port of the AXI write or read master) between `NUM_PORTS` independent requesters, e.g. several video or DMA streams. It latches one requester's burst address and length, issues a single start pulse to the master, waits for that burst's completion, and then rotates to the next requester. Per-port data muxing is done outside this block using `cur_port`.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of requesters; legal range 2..8.
- `ADDR_W`, default 30: burst address width.
- `LEN_W`, default 8: burst length width. The value is passed through unchanged in AXI `len` encoding (beats − 1).
- `IDX_W`, default 2: width of `cur_port`; must equal ceil(log2(`NUM_PORTS`)).

Ports:
- `clk` in 1: single clock, AXI master domain.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req` in `NUM_PORTS`: per-port burst request level.
- `req_addr` in `NUM_PORTS*ADDR_W`: per-port start address. Port p occupies bits [p*ADDR_W +: ADDR_W].
- `req_len` in `NUM_PORTS*LEN_W`: per-port burst length, same packing as `req_addr`.
- `gnt` out `NUM_PORTS`: one-cycle pulse; the port's request has been accepted.
- `done` out `NUM_PORTS`: one-cycle pulse; the port's burst has completed.
- `busy` out 1: high while a burst is owned.
- `cur_port` out `IDX_W`: index of the current or last owner.
- `axi_start` out 1: one-cycle start pulse to the master.
- `axi_addr` out `ADDR_W`: latched burst address.
- `axi_len` out `LEN_W`: latched burst length.
- `axi_ready` in 1: master can accept a start.
- `axi_done` in 1: master burst-complete pulse.

## Operation
- State machine with two states: IDLE and BUSY.
- **IDLE:**
  - If `req` is nonzero and `axi_ready`=1, select a winner, then:
    - latch `cur_port`, `axi_addr` and `axi_len` from the winner's slice;
    - assert `gnt[winner]` and `axi_start` for exactly one cycle;
    - go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:**
  - `req` is ignored.
  - On `axi_done`=1: pulse `done[cur_port]`, set the round-robin pointer `rr_ptr` = (`cur_port`+1) mod `NUM_PORTS`, and go to IDLE.
- **Winner selection (round-robin):** the first set bit of `req` searching upward from `rr_ptr`, wrapping from `NUM_PORTS`−1 to 0.
- **Requester rules:**
  - Hold `req` and the port's address/length slices stable until `gnt` is seen.
  - Drop `req` in the cycle after `gnt`, or keep it high to queue the next burst; it is honoured only after the current burst's `done`.
  - Dropping `req` before `gnt` withdraws the request with no side effects.
- **Boundary conditions:**
  - Address/length changes after `gnt` have no effect on the burst in progress.
  - `axi_done` received in IDLE is ignored; no `done` pulse is produced.
  - With `axi_ready`=0, no grant is issued, even when requests are pending.
  - A port whose `req` stays high alone is re-granted after every `done`.
  - Only one bit of `gnt` or `done` is ever set in any cycle.
- **Reset mid-burst:** state returns to IDLE and `rr_ptr` returns to 0. The master must be reset by the same `rst_n`.

## Timing
- **Reset values:**
  - `gnt`, `done`, `axi_start`, `busy`: 0
  - `axi_addr`, `axi_len`, `cur_port`: 0
  - `rr_ptr`: 0
- All outputs are registered.
- **Request to start:** `req` and `axi_ready` high at edge k → `axi_start`, `gnt` and `busy` are high in the cycle after edge k, so the latency is 1 cycle.
- **Done to done:** `axi_done` high at edge k → `done[p]` high and `busy` low in the cycle after edge k.
- **Back-to-back:** the earliest next `axi_start` is in the cycle after edge k+1. The minimum gap between `axi_done` and the next `axi_start` is 2 cycles.
- `axi_addr`, `axi_len` and `cur_port` are stable from `axi_start` until the next grant.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest-indexed requesting port always wins, and `rr_ptr` is neither updated nor used.
  - Undefined (default): the round-robin selection described under Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
All scenarios use `NUM_PORTS`=4.
- **Reset values:** assert `rst_n`=0 → all outputs are 0. Release, drive `req`=0 for 10 cycles → no `gnt` and no `axi_start`.
- **Single request:** `req`=4'b0100, port 2 address 0x100, length 15 → `axi_start`=1 and `gnt`=4'b0100 one cycle later, `axi_addr`=0x100, `axi_len`=15, `cur_port`=2. Then `axi_done` → `done`=4'b0100 one cycle later.
- **Round-robin fairness:** hold `req`=4'b1111 and return `axi_done` 5 cycles after each start → grant order 0,1,2,3,0. Each `done` to next `axi_start` gap is exactly 2 cycles.
- **Ready stall:** `axi_ready`=0 with `req`=4'b0010 for 20 cycles → no grant. Raise `axi_ready` → `gnt`=4'b0010 one cycle later.
- **Stray done and withdrawal:** pulse `axi_done` in IDLE → no `done`. Assert `req[3]` for 1 cycle while `axi_ready`=0, then drop it → no grant.
- **Reset mid-burst and fixed priority:** assert `rst_n` low in BUSY → IDLE, and the next grant with `req`=4'b1111 goes to port 0. With `ARB_FIXED_PRIO_EN` defined and `req`=4'b1111 held → port 0 is granted every time.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one AXI burst-request port between NUM_PORTS requesters.
// One burst is outstanding at a time. The owner rotates round-robin after each burst completes.
// Defining ARB_FIXED_PRIO_EN builds a fixed-priority variant in which the lowest requesting index wins.
module ddr_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        busy,
    output logic [IDX_W-1:0]            cur_port,
    output logic                        axi_start,
    output logic [ADDR_W-1:0]           axi_addr,
    output logic [LEN_W-1:0]            axi_len,
    input  logic                        axi_ready,
    input  logic                        axi_done
);

    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [IDX_W-1:0]    search_base;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    int unsigned         cand;
    logic [ADDR_W-1:0]   win_addr;
    logic [LEN_W-1:0]    win_len;
    logic [NUM_PORTS-1:0] gnt_d;
    logic [NUM_PORTS-1:0] done_d;
    logic                busy_d;
    logic [IDX_W-1:0]    cur_port_d;
    logic                axi_start_d;
    logic [ADDR_W-1:0]   axi_addr_d;
    logic [LEN_W-1:0]    axi_len_d;

`ifdef ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    assign search_base = rr_ptr;
`endif

    // Winner search: first set req bit at or above search_base, wrapping at NUM_PORTS-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            cand = (32'(search_base) + 32'(i)) % NUM_PORTS;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Extract the winner's address and length slices.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (IDX_W'(p) == win_idx) begin
                win_addr = req_addr[p*ADDR_W +: ADDR_W];
                win_len  = req_len[p*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_d       = '0;
        done_d      = '0;
        axi_start_d = 1'b0;
        cur_port_d  = cur_port;
        axi_addr_d  = axi_addr;
        axi_len_d   = axi_len;
        case (state)
            ST_IDLE: begin
                if (win_found && axi_ready) begin
                    state_d         = ST_BUSY;
                    gnt_d[win_idx]  = 1'b1;
                    axi_start_d     = 1'b1;
                    cur_port_d      = win_idx;
                    axi_addr_d      = win_addr;
                    axi_len_d       = win_len;
                end
            end
            ST_BUSY: begin
                if (axi_done) begin
                    state_d          = ST_IDLE;
                    done_d[cur_port] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d = (cur_port == LAST_PORT) ? '0 : cur_port + IDX_W'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cur_port  <= '0;
            axi_start <= 1'b0;
            axi_addr  <= '0;
            axi_len   <= '0;
        end else begin
            gnt       <= gnt_d;
            done      <= done_d;
            busy      <= busy_d;
            cur_port  <= cur_port_d;
            axi_start <= axi_start_d;
            axi_addr  <= axi_addr_d;
            axi_len   <= axi_len_d;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Testbench for ddr_port_arbiter: a transaction-level model feeds a scoreboard of expected grant and done events.
// A negedge monitor checks those events and the latched burst fields.
module tb_ddr_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 30;
    localparam int LW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     req = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*LW-1:0]  req_len = '0;
    logic              axi_ready = 1'b0;
    logic              axi_done = 1'b0;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     done;
    logic              busy;
    logic [IW-1:0]     cur_port;
    logic              axi_start;
    logic [AW-1:0]     axi_addr;
    logic [LW-1:0]     axi_len;

    ddr_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .done(done), .busy(busy), .cur_port(cur_port),
        .axi_start(axi_start), .axi_addr(axi_addr), .axi_len(axi_len),
        .axi_ready(axi_ready), .axi_done(axi_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_done;
        int          port;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        time         t;
    } ev_t;

    ev_t sb[$];
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cur   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_len   = '0;
    int            m_w;
    ev_t           m_ev;

    function automatic int pick(input logic [NP-1:0] r, input int base);
        for (int i = 0; i < NP; i++) begin
            if (r[(base + i) % NP]) return (base + i) % NP;
        end
        return -1;
    endfunction

    // Model: one owner at a time, winner chosen by the rotating (or fixed) priority rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cur   = 0;
            m_addr  = '0;
            m_len   = '0;
            while (sb.size() > 0 && sb[$].t > $time) void'(sb.pop_back());
        end else if (m_owner < 0) begin
            if (req != '0 && axi_ready) begin
`ifdef ARB_FIXED_PRIO_EN
                m_w = pick(req, 0);
`else
                m_w = pick(req, m_ptr);
`endif
                m_owner = m_w;
                m_cur   = m_w;
                m_addr  = req_addr[m_w*AW +: AW];
                m_len   = req_len[m_w*LW +: LW];
                m_ev.is_done = 1'b0;
                m_ev.port    = m_w;
                m_ev.addr    = m_addr;
                m_ev.len     = m_len;
                m_ev.t       = $time + 5;
                sb.push_back(m_ev);
            end
        end else if (axi_done) begin
            m_ev.is_done = 1'b1;
            m_ev.port    = m_owner;
            m_ev.addr    = m_addr;
            m_ev.len     = m_len;
            m_ev.t       = $time + 5;
            sb.push_back(m_ev);
            m_ptr   = (m_owner + 1) % NP;
            m_owner = -1;
        end
    end

    // ---------------- monitor ----------------
    ev_t mon_ev;
    logic [NP-1:0] exp_g;
    logic [NP-1:0] exp_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {gnt, done, busy, axi_start, cur_port, axi_addr, axi_len}, '0);
        end else begin
            while (sb.size() > 0 && sb[0].t < $time) begin
                chk("missed_event_time", $time, sb[0].t);
                void'(sb.pop_front());
            end
            if (gnt != '0 || done != '0 || axi_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {axi_start, done, gnt}, '0);
                end else begin
                    mon_ev = sb.pop_front();
                    exp_g = '0;
                    exp_d = '0;
                    if (mon_ev.is_done) exp_d[mon_ev.port] = 1'b1;
                    else                exp_g[mon_ev.port] = 1'b1;
                    chk("ev_time", $time, mon_ev.t);
                    chk("ev_gnt", gnt, exp_g);
                    chk("ev_done", done, exp_d);
                    chk("ev_start", axi_start, !mon_ev.is_done);
                end
            end
            chk("busy", busy, m_owner >= 0);
            chk("cur_port", cur_port, m_cur);
            chk("axi_addr", axi_addr, m_addr);
            chk("axi_len", axi_len, m_len);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[p*AW +: AW] = a;
        req_len[p*LW +: LW]  = l;
    endtask

    task automatic pulse_done();
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
    endtask

    task automatic wait_start(output int c, input string name);
        c = -1;
        for (int i = 0; i < 30 && c < 0; i++) begin
            if (axi_start) c = cyc;
            else tick();
        end
        if (c < 0) chk(name, axi_start, 1'b1);
    endtask

    int st;
    int dn;
    int exp_order[5];

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        // reset values, then idle with no requests
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_pulses", {gnt, done, axi_start, busy}, '0);
        chk("rst_fields", {axi_addr, axi_len, cur_port}, '0);
        rst_n = 1'b1;
        axi_ready = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_no_gnt", {axi_start, gnt}, '0);
        end

        // single request on port 2
        set_port(2, AW'(32'h100), LW'(15));
        req = 4'b0100;
        tick();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_start", axi_start, 1'b1);
        chk("single_addr", axi_addr, 30'h100);
        chk("single_len", axi_len, 8'd15);
        chk("single_cur", cur_port, 2'd2);
        req = '0;
        set_port(2, AW'(32'h3ABC), LW'(7));
        repeat (3) tick();
        chk("hold_addr", axi_addr, 30'h100);
        chk("hold_len", axi_len, 8'd15);
        pulse_done();
        chk("single_done", done, 4'b0100);
        chk("single_idle", busy, 1'b0);
        tick();

        // round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int p = 0; p < NP; p++) set_port(p, AW'(32'h1000 * (p + 1)), LW'(p + 1));
        req = 4'b1111;
        dn = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start(st, "rr_start_timeout");
            chk("rr_order", cur_port, exp_order[k]);
            if (k > 0) chk("rr_gap", st - dn, 2);
            repeat (5) tick();
            if (k == 4) req = '0;
            axi_done = 1'b1;
            dn = cyc;
            tick();
            axi_done = 1'b0;
        end
        tick();

        // ready stall
        axi_ready = 1'b0;
        req = 4'b0010;
        repeat (20) begin
            tick();
            chk("stall_no_gnt", {axi_start, gnt}, '0);
        end
        axi_ready = 1'b1;
        tick();
        chk("stall_release_gnt", gnt, 4'b0010);
        req = '0;
        repeat (2) tick();
        pulse_done();
        tick();

        // stray done in idle, then a withdrawn request
        pulse_done();
        chk("stray_done", done, '0);
        chk("stray_busy", busy, 1'b0);
        axi_ready = 1'b0;
        req = 4'b1000;
        tick();
        req = '0;
        axi_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("withdraw_no_gnt", {axi_start, gnt}, '0);
        end

        // randomized traffic
        repeat (1500) begin
            axi_ready = ($urandom_range(0, 9) < 8);
            axi_done  = ($urandom_range(0, 9) < 2);
            for (int p = 0; p < NP; p++) begin
                if (gnt[p]) begin
                    if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
                    set_port(p, AW'($urandom), LW'($urandom));
                end else if (!req[p]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        set_port(p, AW'($urandom), LW'($urandom));
                        req[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req[p] = 1'b0;
                end
            end
            tick();
        end
        req = '0;
        axi_done = 1'b0;
        axi_ready = 1'b1;
        tick();
        for (int i = 0; i < 5 && busy; i++) pulse_done();
        tick();

        // reset in the middle of a burst
        set_port(2, AW'(32'h2222), LW'(3));
        req = 4'b0100;
        tick();
        chk("mid_busy", busy, 1'b1);
        req = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        repeat (2) tick();
        pulse_done();
        chk("post_rst_done", done, 4'b0001);
        repeat (3) tick();

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
